// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: scans NUM_DIGITS common-anode digits through one shared
// 4-bit-to-7-segment decoder. Each slot is BLANK_CYCLES dark followed by a lit
// interval; a shadow copy of the value keeps every frame internally consistent.
// Optional macro DISP_LEADING_ZERO_BLANK_EN darkens leading-zero digits (slot 0
// always lights).
module disp_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int CNT_W        = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   output logic [3:0]              digit_code,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [2:0]              digit_idx,
   output logic                    frame_tick
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BLANK = 2'd1;
   localparam logic [1:0] SHOW  = 2'd2;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);

   logic [1:0]              state, state_n;
   logic [CNT_W-1:0]        cnt, cnt_n;
   logic [2:0]              idx_n;
   logic [4*NUM_DIGITS-1:0] shadow, shadow_n;
   logic [4*NUM_DIGITS-1:0] pend_val, pend_val_n;
   logic                    pend, pend_n;
   logic                    wrap;
   logic [3:0]              code_n;
   logic [NUM_DIGITS-1:0]   anode_n;
   logic                    suppress;
`ifdef DISP_LEADING_ZERO_BLANK_EN
   logic                    zero_above;
`endif

   // Next-state logic: scan sequencing plus shadow/pending load handling.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_n    = state;
      cnt_n      = cnt;
      idx_n      = digit_idx;
      shadow_n   = shadow;
      pend_val_n = pend_val;
      pend_n     = pend;
      wrap       = 1'b0;

      if (!enable) begin
         state_n = IDLE;
         cnt_n   = '0;
         idx_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_n = BLANK;
               cnt_n   = '0;
               idx_n   = '0;
            end
            BLANK: begin
               cnt_n = cnt + 1'b1;
               if (cnt == BLANK_LAST) state_n = SHOW;
            end
            SHOW: begin
               if (cnt == SLOT_LAST) begin
                  state_n = BLANK;
                  cnt_n   = '0;
                  if (digit_idx == IDX_LAST) begin
                     idx_n = '0;
                     wrap  = 1'b1;
                  end else begin
                     idx_n = digit_idx + 1'b1;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
               idx_n   = '0;
            end
         endcase
      end

      // While idle nothing is on display, so the shadow may change directly.
      // While scanning, new values wait in pending until the frame boundary;
      // a load in the wrap cycle itself is folded in first so it is not lost.
      if (state == IDLE) begin
         if (load)      shadow_n = value;
         else if (pend) shadow_n = pend_val;
         pend_n = 1'b0;
      end else begin
         if (load) begin
            pend_val_n = value;
            pend_n     = 1'b1;
         end
         if (wrap) begin
            if (pend_n) shadow_n = pend_val_n;
            pend_n = 1'b0;
         end
      end
   end

   // Output decode from next-state values so the registered outputs line up
   // with the state they describe.
   always_comb begin
      code_n   = 4'd0;
      suppress = 1'b0;
      anode_n  = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_n == i[2:0]) code_n = shadow_n[4*i +: 4];
      end
`ifdef DISP_LEADING_ZERO_BLANK_EN
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above & (shadow_n[4*i +: 4] == 4'd0);
         if ((idx_n == i[2:0]) && zero_above) suppress = 1'b1;
      end
`endif
      if ((state_n == SHOW) && !suppress) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_n == i[2:0]) anode_n[i] = 1'b0;
         end
      end
   end

   // State, counters, value storage and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of the others.
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         digit_idx  <= '0;
         shadow     <= '0;
         pend_val   <= '0;
         pend       <= 1'b0;
         digit_code <= 4'd0;
         anode      <= '1;
         frame_tick <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         digit_idx  <= idx_n;
         shadow     <= shadow_n;
         pend_val   <= pend_val_n;
         pend       <= pend_n;
         digit_code <= code_n;
         anode      <= anode_n;
         frame_tick <= wrap;
      end
   end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2,
// NUM_DIGITS=4: per-frame vector table plus multi-cycle corner sequences.
module tb_disp_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] value;
   logic [3:0]  digit_code;
   logic [3:0]  anode;
   logic [2:0]  digit_idx;
   logic        frame_tick;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   disp_scan_ctrl #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (8),
      .BLANK_CYCLES(2),
      .CNT_W       (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .load      (load),
      .value     (value),
      .digit_code(digit_code),
      .anode     (anode),
      .digit_idx (digit_idx),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] val;
      logic [15:0] codes;  // nibble i: expected digit_code in slot i
      logic [15:0] masks;  // nibble i: expected anode while slot i is lit
   } vec_t;

   vec_t tbl [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      cyc += n;
   endtask

   // Leaves the bench at the negedge of the first BLANK cycle of slot 0.
   task automatic start_frame(input logic [15:0] v);
      enable = 1'b0;
      load   = 1'b0;
      step(1);
      enable = 1'b1;
      load   = 1'b1;
      value  = v;
      step(1);
      load   = 1'b0;
      cyc    = 0;
   endtask

   initial begin
      tbl[0] = '{16'h1234, 16'h1234, 16'h7BDE};
      tbl[1] = '{16'hA5F0, 16'hA5F0, 16'h7BDE};
`ifdef DISP_LEADING_ZERO_BLANK_EN
      tbl[2] = '{16'h0050, 16'h0050, 16'hFFDE};
      tbl[3] = '{16'h0000, 16'h0000, 16'hFFFE};
      tbl[4] = '{16'h0908, 16'h0908, 16'hFBDE};
`else
      tbl[2] = '{16'h0050, 16'h0050, 16'h7BDE};
      tbl[3] = '{16'h0000, 16'h0000, 16'h7BDE};
      tbl[4] = '{16'h0908, 16'h0908, 16'h7BDE};
`endif

      rst_n  = 1'b1;
      enable = 1'b0;
      load   = 1'b0;
      value  = 16'h0;
      #2 rst_n = 1'b0;
      #2;
      check("reset_anode", 32'(anode), 32'hF);
      check("reset_code",  32'(digit_code), 32'h0);
      check("reset_idx",   32'(digit_idx), 32'h0);
      check("reset_tick",  32'(frame_tick), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(2);
      check("idle_anode", 32'(anode), 32'hF);

      // Whole-frame vectors: value loaded while idle, walked cycle by cycle.
      for (int e = 0; e < 5; e++) begin
         start_frame(tbl[e].val);
         for (int c = 0; c < 32; c++) begin
            int slot;
            int cc;
            slot = c / 8;
            cc   = c % 8;
            check("frame_anode", 32'(anode), (cc < 2) ? 32'hF : 32'(tbl[e].masks[4*slot +: 4]));
            check("frame_code",  32'(digit_code), 32'(tbl[e].codes[4*slot +: 4]));
            check("frame_idx",   32'(digit_idx), 32'(slot));
            check("frame_tick_low", 32'(frame_tick), 32'h0);
            step(1);
         end
         check("wrap_tick",  32'(frame_tick), 32'h1);
         check("wrap_idx",   32'(digit_idx), 32'h0);
         check("wrap_anode", 32'(anode), 32'hF);
         check("wrap_code",  32'(digit_code), 32'(tbl[e].codes[3:0]));
         step(1);
         check("tick_one_cycle", 32'(frame_tick), 32'h0);
      end

      // Load during slot 2 waits for the frame boundary.
      start_frame(16'h1234);
      step(16);
      load  = 1'b1;
      value = 16'h5678;
      step(1);
      load  = 1'b0;
      step(3);
      check("pend_slot2_code",  32'(digit_code), 32'h2);
      check("pend_slot2_anode", 32'(anode), 32'hB);
      step(8);
      check("pend_slot3_code",  32'(digit_code), 32'h1);
      step(4);
      check("pend_new_code0", 32'(digit_code), 32'h8);
      check("pend_new_tick",  32'(frame_tick), 32'h1);
      step(10);
      check("pend_new_code1", 32'(digit_code), 32'h7);
      step(8);
      check("pend_new_code2", 32'(digit_code), 32'h6);
      step(8);
      check("pend_new_code3",  32'(digit_code), 32'h5);
      check("pend_new_anode3", 32'(anode), 32'h7);

      // Drop enable mid-SHOW of slot 1, then re-enable.
      start_frame(16'h1234);
      step(12);
      check("dis_pre_anode", 32'(anode), 32'hD);
      enable = 1'b0;
      step(1);
      check("dis_anode", 32'(anode), 32'hF);
      check("dis_idx",   32'(digit_idx), 32'h0);
      enable = 1'b1;
      step(1);
      check("reen_blank0_anode", 32'(anode), 32'hF);
      check("reen_blank0_code",  32'(digit_code), 32'h4);
      check("reen_tick",         32'(frame_tick), 32'h0);
      step(1);
      check("reen_blank1_anode", 32'(anode), 32'hF);
      step(1);
      check("reen_show_anode", 32'(anode), 32'hE);

      // Asynchronous reset with a pending load discards the pending value.
      start_frame(16'h1234);
      step(5);
      load  = 1'b1;
      value = 16'h9999;
      step(1);
      load  = 1'b0;
      check("rst_pre_code", 32'(digit_code), 32'h4);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_anode", 32'(anode), 32'hF);
      check("rst_async_code",  32'(digit_code), 32'h0);
      check("rst_async_idx",   32'(digit_idx), 32'h0);
      @(negedge clk);
      rst_n  = 1'b1;
      enable = 1'b1;
      cyc    = -1;
      step(1);
      check("rst_after_blank_anode", 32'(anode), 32'hF);
      step(2);
      check("rst_after_show_anode", 32'(anode), 32'hE);
      check("rst_after_code0",      32'(digit_code), 32'h0);
      step(8);
      check("rst_after_code1", 32'(digit_code), 32'h0);
      check("rst_after_idx1",  32'(digit_idx), 32'h1);

      // Load in the wrap cycle, then back-to-back loads before the next wrap.
      start_frame(16'h1234);
      step(31);
      check("lw_pre_code",  32'(digit_code), 32'h1);
      check("lw_pre_anode", 32'(anode), 32'h7);
      load  = 1'b1;
      value = 16'hCAFE;
      step(1);
      load  = 1'b0;
      check("lw_code0", 32'(digit_code), 32'hE);
      check("lw_tick",  32'(frame_tick), 32'h1);
      step(2);
      load  = 1'b1;
      value = 16'h1111;
      step(1);
      value = 16'h4321;
      step(1);
      load  = 1'b0;
      step(6);
      check("b2b_cur_code1", 32'(digit_code), 32'hF);
      step(22);
      check("b2b_code0", 32'(digit_code), 32'h1);
      check("b2b_tick",  32'(frame_tick), 32'h1);
      step(10);
      check("b2b_code1", 32'(digit_code), 32'h2);
      step(16);
      check("b2b_code3", 32'(digit_code), 32'h4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
